sram_port_arbiter: RTL

- Shares the single external SRAM port among up to NUM_REQ requesters, for example the UART loader, the colourspace-conversion/upsampling milestone, the IDCT milestone and the VGA reader.
- Grants are round-robin and ownership is held for as long as the requester keeps its request high.
- The owner's address, write data and write enable are registered onto the SRAM port.
- Each read issued through the port is tagged, and read-data validity is returned to the owner that issued it, even after the grant has moved on.
- Sits between the milestone controllers and the SRAM interface in the top level.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 27 ++
 rtl/sram_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and FSM state type for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 16;
  localparam int SRAM_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    S_ARB_IDLE,
    S_ARB_OWN,
    S_ARB_HANDOVER
  } arb_state_type;

  // Round-robin successor of requester k among n requesters.
  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        pick_o[cand] = 1'b1;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin owner arbitration of one SRAM port, with registered port outputs
// and a tag pipeline that routes read-data validity back to the issuing requester.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int RD_LATENCY = SRAM_RD_LATENCY
) (
  input  logic                      CLOCK_50_I,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
  input  logic [NUM_REQ-1:0]        req_we_n,
  input  logic [NUM_REQ-1:0]        req_rd_en,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [ADDR_W-1:0]         SRAM_address,
  output logic [DATA_W-1:0]         SRAM_write_data,
  output logic                      SRAM_we_n,
  input  logic [DATA_W-1:0]         SRAM_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_type      state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_n_q, we_n_d;

  logic [RD_LATENCY:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]    tag_id_q [RD_LATENCY+1];
  logic [IDX_W-1:0]    tag_id_d [RD_LATENCY+1];

  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               issue;

  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_address[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_write_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // IDLE and HANDOVER arbitrate identically; HANDOVER differs only in being
  // entered from a release, which has already advanced the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    issue   = 1'b0;
    unique case (state_q)
      S_ARB_IDLE, S_ARB_HANDOVER: begin
        grant_d = '0;
        state_d = S_ARB_IDLE;
        if (pick_any) begin
          grant_d = pick;
          owner_d = pick_idx;
          state_d = S_ARB_OWN;
        end
      end
      S_ARB_OWN: begin
        if (req[owner_q]) begin
          addr_d  = addr_a[owner_q];
          wdata_d = wdata_a[owner_q];
          we_n_d  = req_we_n[owner_q];
          issue   = req_we_n[owner_q] & req_rd_en[owner_q];
        end else begin
          grant_d = '0;
          ptr_d   = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
          state_d = S_ARB_HANDOVER;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    tag_vld_d   = {tag_vld_q[RD_LATENCY-1:0], issue};
    tag_id_d[0] = owner_q;
    for (int unsigned i = 1; i <= RD_LATENCY; i++) begin
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_ARB_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_n_q    <= 1'b1;
      tag_vld_q <= '0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_n_q    <= we_n_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (tag_vld_q[RD_LATENCY]) rd_valid[tag_id_q[RD_LATENCY]] = 1'b1;
  end

  assign grant           = grant_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;

  a_grant_onehot: assert property (@(posedge CLOCK_50_I) disable iff (Reset) $onehot0(grant));
  a_rd_data_known: assert property (@(posedge CLOCK_50_I) disable iff (Reset)
    (|rd_valid) |-> !$isunknown(SRAM_read_data));

endmodule
